// File: rtl/cotm32_pkg.sv
//------------------------------------------------------------------------------
// Module   : cotm32_pkg
// Purpose  : Shared core types and constants: XLEN, data-memory window,
//            LSU access kinds and data-memory response error codes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cotm32_pkg;

    localparam int          XLEN            = 32;
    localparam logic [31:0] DATA_MEM_START  = 32'h1000_0000;
    localparam int          DATA_MEM_SIZE   = 4096;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LBU  = 4'd4,
        LSU_LHU  = 4'd5,
        LSU_SB   = 4'd6,
        LSU_SH   = 4'd7,
        LSU_SW   = 4'd8
    } lsu_ls_t;

    typedef enum logic [1:0] {
        DMEM_ERR_NONE     = 2'd0,
        DMEM_ERR_MISALIGN = 2'd1,
        DMEM_ERR_RANGE    = 2'd2
    } dmem_err_t;

    function automatic logic lsu_is_store(input lsu_ls_t op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic lsu_is_load(input lsu_ls_t op);
        return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
               (op == LSU_LBU) || (op == LSU_LHU);
    endfunction

    // Halfword accesses need an even address, word accesses a 4-byte one.
    function automatic logic lsu_misaligned(input lsu_ls_t op, input logic [1:0] lo);
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: return lo[0];
            LSU_LW, LSU_SW:          return |lo;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_ram.sv
//------------------------------------------------------------------------------
// Module   : dmem_ram
// Purpose  : Word-organised data RAM, byte-enable synchronous write and
//            synchronous (registered) read. Contents are never reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:WORDS-1];

    // Byte-lane write and registered read of the addressed word
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        if (i_en) begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
//------------------------------------------------------------------------------
// Module   : dmem_responder
// Purpose  : LSU-facing data-memory responder. Accepts one request at a time,
//            optionally inserts wait cycles, checks alignment then range,
//            and returns a sign/zero-extended load result or an error code.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_responder
    import cotm32_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DATA_MEM_START,
    parameter int          SIZE_BYTES  = DATA_MEM_SIZE,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  lsu_ls_t         req_op,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output dmem_err_t       rsp_err
);

    localparam int          c_WORDS = SIZE_BYTES / 4;
    localparam int          c_AW    = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam logic [32:0] c_LAST  = {1'b0, BASE_ADDR} + 33'(SIZE_BYTES) - 33'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic [3:0]      r_wait_cnt, w_wait_cnt_next;
    logic            w_enter_resp;
    logic            w_accept;
    lsu_ls_t         r_op;
    logic [XLEN-1:0] r_addr, r_wdata;
    dmem_err_t       r_err;

    lsu_ls_t         w_cur_op;
    logic [XLEN-1:0] w_cur_addr, w_cur_wdata, w_offset;
    dmem_err_t       w_err;
    logic [c_AW-1:0] w_word;
    logic [3:0]      w_be, w_ram_we;
    logic [31:0]     w_ram_wdata, w_ram_rdata;
    logic            w_ram_re;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load;

    assign w_accept = req_valid && (r_state == ST_IDLE);

    // With no wait cycles the access happens on the accepting edge, so the
    // live inputs are used in IDLE; afterwards only the latched copy counts.
    assign w_cur_op    = (r_state == ST_IDLE) ? req_op    : r_op;
    assign w_cur_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
    assign w_offset    = w_cur_addr - BASE_ADDR;
    assign w_word      = c_AW'(w_offset >> 2);

    // Alignment is checked before range; a no-op is never an error
    always_comb begin
        w_err = DMEM_ERR_NONE;
        if (lsu_misaligned(w_cur_op, w_cur_addr[1:0])) begin
            w_err = DMEM_ERR_MISALIGN;
        end else if ((w_cur_op != LSU_NONE) &&
                     (({1'b0, w_cur_addr} < {1'b0, BASE_ADDR}) ||
                      ({1'b0, w_cur_addr} > c_LAST))) begin
            w_err = DMEM_ERR_RANGE;
        end
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        w_be        = 4'b0000;
        w_ram_wdata = w_cur_wdata;
        case (w_cur_op)
            LSU_SB: begin
                w_be        = 4'b0001 << w_cur_addr[1:0];
                w_ram_wdata = {4{w_cur_wdata[7:0]}};
            end
            LSU_SH: begin
                w_be        = w_cur_addr[1] ? 4'b1100 : 4'b0011;
                w_ram_wdata = {2{w_cur_wdata[15:0]}};
            end
            LSU_SW:  w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_ram_we = (w_enter_resp && (w_err == DMEM_ERR_NONE)) ? w_be : 4'b0000;
    assign w_ram_re = w_enter_resp && (w_err == DMEM_ERR_NONE) && lsu_is_load(w_cur_op);

    dmem_ram #(
        .WORDS (c_WORDS),
        .AW    (c_AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_re),
        .i_we    (w_ram_we),
        .i_addr  (w_word),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // State register and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // Next-state logic; flags the edge on which the memory is accessed
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_enter_resp    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_next = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_next    = ST_WAIT;
                        w_wait_cnt_next = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_state_next = ST_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Capture the request on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= LSU_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_op    <= req_op;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Capture the error code together with the memory access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= DMEM_ERR_NONE;
        end else if (w_enter_resp) begin
            r_err <= w_err;
        end
    end

    assign w_byte = w_ram_rdata[8*r_addr[1:0] +: 8];
    assign w_half = r_addr[1] ? w_ram_rdata[31:16] : w_ram_rdata[15:0];

    // Extend the sampled lanes according to the load kind
    always_comb begin
        w_load = '0;
        case (r_op)
            LSU_LB:  w_load = {{24{w_byte[7]}}, w_byte};
            LSU_LBU: w_load = {24'd0, w_byte};
            LSU_LH:  w_load = {{16{w_half[15]}}, w_half};
            LSU_LHU: w_load = {16'd0, w_half};
            LSU_LW:  w_load = w_ram_rdata;
            default: w_load = '0;
        endcase
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = (r_state == ST_RESP) ? r_err : DMEM_ERR_NONE;
    assign rsp_rdata = ((r_state == ST_RESP) && (r_err == DMEM_ERR_NONE)) ? w_load : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_dmem_responder
// Purpose  : Self-checking bench for dmem_responder: directed vector table,
//            randomized traffic against a byte-level reference model, and
//            wait-state / back-pressure / reset-abort sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;
    import cotm32_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          SIZE = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: no wait cycles
    logic        a_rst_n, a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    lsu_ls_t     a_req_op;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    dmem_err_t   a_rsp_err;
    // Instance B: two wait cycles
    logic        b_rst_n, b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    lsu_ls_t     b_req_op;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    dmem_err_t   b_rsp_err;

    dmem_responder #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .WAIT_CYCLES(0)) u_dut_a (
        .clk(clk), .rst_n(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_op(a_req_op), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err));

    dmem_responder #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .WAIT_CYCLES(2)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_op(b_req_op), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err));

    int total = 0;
    int bad   = 0;

    logic [7:0] mref [0:SIZE-1];

    typedef struct {
        lsu_ls_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        dmem_err_t   err;
    } vec_t;

    vec_t vt [20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit v, input lsu_ls_t op,
                         input logic [31:0] a, input logic [31:0] w);
        if (!sel) begin
            a_req_valid = v; a_req_op = op; a_req_addr = a; a_req_wdata = w;
        end else begin
            b_req_valid = v; b_req_op = op; b_req_addr = a; b_req_wdata = w;
        end
    endtask

    task automatic set_rready(input bit sel, input bit r);
        if (!sel) a_rsp_ready = r;
        else      b_rsp_ready = r;
    endtask

    function automatic logic g_valid(input bit sel);
        return sel ? b_rsp_valid : a_rsp_valid;
    endfunction
    function automatic logic g_ready(input bit sel);
        return sel ? b_req_ready : a_req_ready;
    endfunction
    function automatic logic [31:0] g_rdata(input bit sel);
        return sel ? b_rsp_rdata : a_rsp_rdata;
    endfunction
    function automatic logic [31:0] g_err(input bit sel);
        return sel ? 32'(b_rsp_err) : 32'(a_rsp_err);
    endfunction

    // One complete request/response; hold>0 keeps rsp_ready low that many
    // cycles while a conflicting store is offered, which must be ignored.
    task automatic xact(input bit sel, input lsu_ls_t op, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output dmem_err_t err, output int lat);
        rd  = '0;
        err = DMEM_ERR_NONE;
        lat = 0;
        @(negedge clk);
        drive(sel, 1'b1, op, addr, wd);
        check("req_ready_idle", 32'(g_ready(sel)), 32'd1);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, LSU_SW, $urandom, $urandom);
        do begin
            @(negedge clk);
            lat++;
        end while (!g_valid(sel) && lat < 20);
        if (!g_valid(sel)) begin
            check("rsp_timeout", 32'(g_valid(sel)), 32'd1);
            return;
        end
        rd  = g_rdata(sel);
        err = dmem_err_t'(g_err(sel));
        check("req_ready_busy", 32'(g_ready(sel)), 32'd0);
        if (hold > 0) drive(sel, 1'b1, LSU_SW, addr & 32'hFFFF_FFFC, 32'hBAD0_BAD0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(g_valid(sel)), 32'd1);
            check("hold_rdata", g_rdata(sel), rd);
            check("hold_err", g_err(sel), 32'(err));
            check("hold_ready", 32'(g_ready(sel)), 32'd0);
        end
        drive(sel, 1'b0, LSU_NONE, '0, '0);
        set_rready(sel, 1'b1);
        @(posedge clk);
        #1;
        set_rready(sel, 1'b0);
        @(negedge clk);
        check("after_hs", {30'd0, g_valid(sel), g_ready(sel)}, 32'd1);
    endtask

    // Reference: byte-addressed memory and the access rules, no state machine
    task automatic model(input lsu_ls_t op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output dmem_err_t err);
        int n = 0;
        bit st = 0, sx = 0;
        logic [31:0] v = '0;
        int off;
        rd  = '0;
        err = DMEM_ERR_NONE;
        case (op)
            LSU_LB:  begin n = 1; sx = 1; end
            LSU_LBU: n = 1;
            LSU_LH:  begin n = 2; sx = 1; end
            LSU_LHU: n = 2;
            LSU_LW:  n = 4;
            LSU_SB:  begin n = 1; st = 1; end
            LSU_SH:  begin n = 2; st = 1; end
            LSU_SW:  begin n = 4; st = 1; end
            default: n = 0;
        endcase
        if (n == 0) return;
        if ((addr % n) != 0) begin
            err = DMEM_ERR_MISALIGN;
        end else if (longint'(addr) < longint'(BASE) ||
                     longint'(addr) > longint'(BASE) + SIZE - 1) begin
            err = DMEM_ERR_RANGE;
        end else begin
            off = int'(addr - BASE);
            if (st) begin
                for (int i = 0; i < n; i++) mref[off + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = mref[off + i];
                if (n == 1)      rd = sx ? {{24{v[7]}}, v[7:0]}   : {24'd0, v[7:0]};
                else if (n == 2) rd = sx ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
                else             rd = v;
            end
        end
    endtask

    initial begin
        logic [31:0] rd, mrd, a;
        dmem_err_t   err, merr;
        int          lat;
        lsu_ls_t     op;

        vt[0]  = '{LSU_SW,  BASE + 32'h4,   32'hDEAD_BEEF, 32'h0,         DMEM_ERR_NONE};
        vt[1]  = '{LSU_LW,  BASE + 32'h4,   32'h0,         32'hDEAD_BEEF, DMEM_ERR_NONE};
        vt[2]  = '{LSU_SB,  BASE + 32'h7,   32'h0000_0080, 32'h0,         DMEM_ERR_NONE};
        vt[3]  = '{LSU_LB,  BASE + 32'h7,   32'h0,         32'hFFFF_FF80, DMEM_ERR_NONE};
        vt[4]  = '{LSU_LBU, BASE + 32'h7,   32'h0,         32'h0000_0080, DMEM_ERR_NONE};
        vt[5]  = '{LSU_LW,  BASE + 32'h4,   32'h0,         32'h80AD_BEEF, DMEM_ERR_NONE};
        vt[6]  = '{LSU_LH,  BASE + 32'h1,   32'h0,         32'h0,         DMEM_ERR_MISALIGN};
        vt[7]  = '{LSU_SW,  BASE + 32'h6,   32'h1111_2222, 32'h0,         DMEM_ERR_MISALIGN};
        vt[8]  = '{LSU_LW,  BASE + 32'h4,   32'h0,         32'h80AD_BEEF, DMEM_ERR_NONE};
        vt[9]  = '{LSU_LW,  32'h1000_1000,  32'h0,         32'h0,         DMEM_ERR_RANGE};
        vt[10] = '{LSU_SW,  32'h0FFF_FFFC,  32'h5555_AAAA, 32'h0,         DMEM_ERR_RANGE};
        vt[11] = '{LSU_NONE, BASE + 32'h4,  32'hFFFF_FFFF, 32'h0,         DMEM_ERR_NONE};
        vt[12] = '{LSU_SH,  BASE + 32'h6,   32'h1234_ABCD, 32'h0,         DMEM_ERR_NONE};
        vt[13] = '{LSU_LW,  BASE + 32'h4,   32'h0,         32'hABCD_BEEF, DMEM_ERR_NONE};
        vt[14] = '{LSU_LHU, BASE + 32'h6,   32'h0,         32'h0000_ABCD, DMEM_ERR_NONE};
        vt[15] = '{LSU_LH,  BASE + 32'h6,   32'h0,         32'hFFFF_ABCD, DMEM_ERR_NONE};
        vt[16] = '{LSU_LH,  BASE + 32'h4,   32'h0,         32'hFFFF_BEEF, DMEM_ERR_NONE};
        vt[17] = '{LSU_SW,  BASE + 32'hFFC, 32'hCAFE_F00D, 32'h0,         DMEM_ERR_NONE};
        vt[18] = '{LSU_LB,  BASE + 32'hFFF, 32'h0,         32'hFFFF_FFCA, DMEM_ERR_NONE};
        vt[19] = '{LSU_LW,  BASE + 32'hFFC, 32'h0,         32'hCAFE_F00D, DMEM_ERR_NONE};

        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
        drive(1'b0, 1'b0, LSU_NONE, '0, '0);
        drive(1'b1, 1'b0, LSU_NONE, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_req_ready", 32'(g_ready(s[0])), 32'd1);
            check("rst_rsp_valid", 32'(g_valid(s[0])), 32'd0);
            check("rst_rsp_rdata", g_rdata(s[0]), 32'd0);
            check("rst_rsp_err",   g_err(s[0]), 32'(DMEM_ERR_NONE));
        end
        a_rst_n = 1'b1; b_rst_n = 1'b1;

        // Directed vectors on the zero-wait instance
        for (int i = 0; i < 20; i++) begin
            xact(1'b0, vt[i].op, vt[i].addr, vt[i].wdata, 0, rd, err, lat);
            check($sformatf("vec%0d_rdata", i), rd, vt[i].rdata);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
        end

        // Preload the low and high windows so random reads are well defined
        for (int off = 0; off < SIZE; off += 4) begin
            if (off == 64) off = SIZE - 16;
            a = BASE + 32'(off);
            model(LSU_SW, a, $urandom, mrd, merr);
            xact(1'b0, LSU_SW, a, {mref[off+3], mref[off+2], mref[off+1], mref[off]},
                 0, rd, err, lat);
            check("preload_err", 32'(err), 32'(DMEM_ERR_NONE));
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = BASE + 32'($urandom_range(0, 63));
                3:       a = BASE + 32'(SIZE - 16) + 32'($urandom_range(0, 15));
                4:       a = BASE - 32'd4 + 32'($urandom_range(0, 3));
                default: a = BASE + 32'(SIZE) + 32'($urandom_range(0, 7));
            endcase
            op = lsu_ls_t'($urandom_range(0, 8));
            rd = $urandom;
            model(op, a, rd, mrd, merr);
            xact(1'b0, op, a, rd, 0, rd, err, lat);
            check($sformatf("rnd%0d_rdata op=%0d addr=%08h", i, op, a), rd, mrd);
            check($sformatf("rnd%0d_err", i), 32'(err), 32'(merr));
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd1);
        end

        // Two-wait-cycle instance: latency and back-pressure stability
        xact(1'b1, LSU_SW, BASE + 32'h8, 32'h1111_1111, 0, rd, err, lat);
        check("w2_sw_err", 32'(err), 32'(DMEM_ERR_NONE));
        check("w2_sw_latency", 32'(lat), 32'd3);
        xact(1'b1, LSU_LW, BASE + 32'h8, 32'h0, 4, rd, err, lat);
        check("w2_lw_rdata", rd, 32'h1111_1111);
        check("w2_lw_latency", 32'(lat), 32'd3);
        xact(1'b1, LSU_LW, BASE + 32'h8, 32'h0, 0, rd, err, lat);
        check("w2_ignored_store", rd, 32'h1111_1111);

        // Reset while a store is still waiting: it must never commit
        @(negedge clk);
        drive(1'b1, 1'b1, LSU_SW, BASE + 32'h8, 32'h1234_5678);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, LSU_NONE, '0, '0);
        @(negedge clk);
        check("abort_in_wait", {30'd0, b_rsp_valid, b_req_ready}, 32'd0);
        b_rst_n = 1'b0;
        #1;
        check("abort_req_ready", 32'(b_req_ready), 32'd1);
        check("abort_rsp_valid", 32'(b_rsp_valid), 32'd0);
        check("abort_rsp_rdata", b_rsp_rdata, 32'd0);
        check("abort_rsp_err",   32'(b_rsp_err), 32'(DMEM_ERR_NONE));
        repeat (3) @(posedge clk);
        @(negedge clk);
        b_rst_n = 1'b1;
        xact(1'b1, LSU_LW, BASE + 32'h8, 32'h0, 0, rd, err, lat);
        check("abort_word_unchanged", rd, 32'h1111_1111);
        check("abort_word_err", 32'(err), 32'(DMEM_ERR_NONE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default DATA_MEM_START, meaning first byte address served.
REQ-002 SHALL have parameter SIZE_BYTES, default DATA_MEM_SIZE, meaning capacity; a multiple of 4.
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, meaning extra access cycles inserted before each response (0..15).
REQ-004 SHALL have the port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have the port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have the port req_valid  in  1  LSU request present.
REQ-007 SHALL have the port req_ready  out  1  responder accepts request.
REQ-008 SHALL have the port req_op  in  lsu_ls_t  load/store kind.
REQ-009 SHALL have the port req_addr  in  XLEN  byte address.
REQ-010 SHALL have the port req_wdata  in  XLEN  store data, low-aligned.
REQ-011 SHALL have the port rsp_valid  out  1  response present.
REQ-012 SHALL have the port rsp_ready  in  1  LSU takes response.
REQ-013 SHALL have the port rsp_rdata  out  XLEN  load result, already sign/zero extended.
REQ-014 SHALL have the port rsp_err  out  dmem_err_t  DMEM_ERR_NONE / DMEM_ERR_MISALIGN / DMEM_ERR_RANGE.

Function
REQ-015 SHALL implement FSM IDLE -> (WAIT_CYCLES>0 ? WAIT : RESP) -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-016 SHALL accept on req_valid&&req_ready, latching op/addr/wdata; inputs are ignored outside IDLE.
REQ-017 SHALL count WAIT_CYCLES cycles in WAIT; with WAIT_CYCLES=0, rsp_valid rises on the cycle after acceptance, otherwise WAIT_CYCLES cycles later.
REQ-018 SHALL perform the memory access (store commit, read sample) on the clock edge that enters RESP, and only then.
REQ-019 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready; on rsp_valid&&rsp_ready, go to IDLE with rsp_valid=0 on the next cycle.
REQ-020 SHALL check alignment first: H/HU/store-H need addr[0]=0; W/store-W need addr[1:0]=0; failure -> DMEM_ERR_MISALIGN.
REQ-021 SHALL check range next: addr < BASE_ADDR or addr > BASE_ADDR+SIZE_BYTES-1 (32-bit unsigned compare, no wrap) -> DMEM_ERR_RANGE.
REQ-022 SHALL, on any error, write no memory and drive rsp_rdata=0.
REQ-023 SHALL index by offset=addr-BASE_ADDR; word=offset[..:2]; lane=addr[1:0].
REQ-024 SHALL store B as wdata[7:0] to the lane, H as wdata[15:0] to lanes {addr[1],0..1}, W as all 4 lanes; other bytes untouched.
REQ-025 SHALL return LB/LH sign-extended, LBU/LHU zero-extended from the addressed lane(s), and LW as the full word.
REQ-026 SHALL treat LSU_NONE as a legal no-op: full handshake, rdata 0, DMEM_ERR_NONE, no write.

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=DMEM_ERR_NONE, and the wait counter to 0.
REQ-028 SHALL abandon any request in progress on reset; a store not yet committed (REQ-018) SHALL never be written.
REQ-029 SHALL NOT reset memory contents.

Structure
REQ-030 SHALL add dmem_err_t (2-bit enum) to cotm32_pkg; lsu_ls_t, XLEN and DATA_MEM_* come from cotm32_pkg.
REQ-031 SHALL instantiate one sub-module dmem_ram: SIZE_BYTES/4 words, 4-bit byte-enable synchronous write, synchronous read.

Verification
REQ-032 SHALL verify: SW 0xDEADBEEF @0x1000_0004, then LW @0x1000_0004 -> 0xDEADBEEF, DMEM_ERR_NONE, rsp_valid exactly 1 cycle after acceptance (WAIT_CYCLES=0).
REQ-033 SHALL verify: SB wdata 0x80 @0x1000_0007; LB -> 0xFFFF_FF80; LBU -> 0x0000_0080; LW @0x1000_0004 -> 0x80AD_BEEF.
REQ-034 SHALL verify: LH @0x1000_0001 -> DMEM_ERR_MISALIGN, rdata 0; SW @0x1000_0006 -> DMEM_ERR_MISALIGN, word unchanged.
REQ-035 SHALL verify: LW @0x1000_1000 -> DMEM_ERR_RANGE; SW @0x0FFF_FFFC -> DMEM_ERR_RANGE, no write.
REQ-036 SHALL verify: WAIT_CYCLES=2 gives rsp_valid 3 cycles after acceptance; holding rsp_ready=0 for 4 cycles keeps outputs stable and req_ready=0.
REQ-037 SHALL verify: rst_n pulsed low in WAIT during SW 0x1234_5678 -> outputs take reset values immediately and the target word is unchanged.
